// File: rtl/fp_pkg.sv
// Shared constants, float field layout and FSM state type for the align/add datapath.
package fp_pkg;

  localparam int unsigned MANTISSA_N = 25;   // carry + hidden + fraction
  localparam int unsigned EXP_N      = 8;
  localparam int unsigned FRAC_N     = 23;
  localparam int unsigned BIAS       = 127;
  localparam int unsigned SHIFT_CAP  = 25;   // beyond this the small operand is all zeros

  typedef struct packed {
    logic              sign;
    logic [EXP_N-1:0]  exp;
    logic [FRAC_N-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StAdd,
    StDone
  } state_e;

endpackage

// File: rtl/fp_align_add_if.sv
// Operand/result handshake bundle between the producer, fp_align_add and the normalizer.
interface fp_align_add_if #(
  parameter int unsigned MANTISSA_N = fp_pkg::MANTISSA_N,
  parameter int unsigned EXP_N      = fp_pkg::EXP_N
);
  logic [31:0]           a;
  logic [31:0]           b;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sign;
  logic [EXP_N-1:0]      exp;
  logic [MANTISSA_N-1:0] mantissa;
  logic                  shiftRight;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out_valid, sign, exp, mantissa, shiftRight
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out_valid, sign, exp, mantissa, shiftRight
  );
endinterface

// File: rtl/fp_unpack.sv
// Splits a single-precision word into sign, exponent and {hidden, fraction} significand.
module fp_unpack
  import fp_pkg::*;
(
  input  fp32_t             op_i,
  output logic              sign_o,
  output logic [EXP_N-1:0]  exp_o,
  output logic [FRAC_N:0]   sig_o
);
  // Hidden bit is implied for every non-zero exponent, including 255.
  assign sign_o = op_i.sign;
  assign exp_o  = op_i.exp;
  assign sig_o  = {op_i.exp != '0, op_i.frac};
endmodule

// File: rtl/fp_align_add.sv
// Aligns two single-precision operands one bit per cycle and adds their magnitudes,
// producing an unnormalized {sign, exp, mantissa} for a downstream normalizer.
module fp_align_add #(
  parameter int unsigned MANTISSA_N = fp_pkg::MANTISSA_N,
  parameter int unsigned EXP_N      = fp_pkg::EXP_N
) (
  input logic           clock,
  input logic           reset,
  fp_align_add_if.slave bus_io
);
  import fp_pkg::*;

  localparam int unsigned SigW = MANTISSA_N - 1;  // hidden + fraction
  localparam int unsigned CntW = $clog2(SHIFT_CAP + 1);

  fp32_t            op_a, op_b;
  logic             a_sign, b_sign;
  logic [EXP_N-1:0] a_exp, b_exp;
  logic [SigW-1:0]  a_sig, b_sig;

  assign op_a = bus_io.a;
  assign op_b = bus_io.b;

  fp_unpack u_unpack_a (.op_i(op_a), .sign_o(a_sign), .exp_o(a_exp), .sig_o(a_sig));
  fp_unpack u_unpack_b (.op_i(op_b), .sign_o(b_sign), .exp_o(b_exp), .sig_o(b_sig));

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SigW-1:0]       big_sig_q, big_sig_d, small_sig_q, small_sig_d;
  logic                  big_sign_q, big_sign_d, small_sign_q, small_sign_d;
  logic [EXP_N-1:0]      big_exp_q, big_exp_d;
  logic                  sign_q, sign_d;
  logic [EXP_N-1:0]      exp_q, exp_d;
  logic [MANTISSA_N-1:0] mant_q, mant_d;

  logic [EXP_N-1:0]      exp_diff;
  logic [MANTISSA_N-1:0] sum;
  logic                  res_sign;

  // Next-state, operand capture, alignment shift and magnitude add.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    big_sig_d    = big_sig_q;
    small_sig_d  = small_sig_q;
    big_sign_d   = big_sign_q;
    small_sign_d = small_sign_q;
    big_exp_d    = big_exp_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    mant_d       = mant_q;
    exp_diff     = '0;
    sum          = '0;
    res_sign     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          // Ties on exponent keep A as the big operand.
          if (a_exp >= b_exp) begin
            big_sig_d    = a_sig;
            big_sign_d   = a_sign;
            big_exp_d    = a_exp;
            small_sig_d  = b_sig;
            small_sign_d = b_sign;
            exp_diff     = a_exp - b_exp;
          end else begin
            big_sig_d    = b_sig;
            big_sign_d   = b_sign;
            big_exp_d    = b_exp;
            small_sig_d  = a_sig;
            small_sign_d = a_sign;
            exp_diff     = b_exp - a_exp;
          end
          cnt_d   = (exp_diff > EXP_N'(SHIFT_CAP)) ? CntW'(SHIFT_CAP) : CntW'(exp_diff);
          state_d = (exp_diff != '0) ? StAlign : StAdd;
        end
      end
      StAlign: begin
        small_sig_d = small_sig_q >> 1;
        cnt_d       = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StAdd;
      end
      StAdd: begin
        if (big_sign_q == small_sign_q) begin
          sum      = {1'b0, big_sig_q} + {1'b0, small_sig_q};
          res_sign = big_sign_q;
        end else if (big_sig_q >= small_sig_q) begin
          sum      = {1'b0, big_sig_q} - {1'b0, small_sig_q};
          res_sign = big_sign_q;
        end else begin
          sum      = {1'b0, small_sig_q} - {1'b0, big_sig_q};
          res_sign = small_sign_q;
        end
        sign_d  = (sum == '0) ? 1'b0 : res_sign;
        exp_d   = big_exp_q;
        mant_d  = sum;
        state_d = StDone;
      end
      StDone: begin
        if (bus_io.out_ready) state_d = StIdle;
      end
    endcase
  end

  // State, operand and result registers; reset discards any in-flight operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      big_sig_q    <= '0;
      small_sig_q  <= '0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      big_exp_q    <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      mant_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      big_sig_q    <= big_sig_d;
      small_sig_q  <= small_sig_d;
      big_sign_q   <= big_sign_d;
      small_sign_q <= small_sign_d;
      big_exp_q    <= big_exp_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      mant_q       <= mant_d;
    end
  end

  assign bus_io.in_ready   = (state_q == StIdle);
  assign bus_io.out_valid  = (state_q == StDone);
  assign bus_io.sign       = sign_q;
  assign bus_io.exp        = exp_q;
  assign bus_io.mantissa   = mant_q;
  assign bus_io.shiftRight = mant_q[MANTISSA_N-1];
endmodule

// File: tb/tb_fp_align_add.sv
// Bench for fp_align_add: directed vector table, stall and reset sequences, random operands
// against a signed-integer reference model.
module tb_fp_align_add;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fp_align_add_if bus ();

  fp_align_add dut (
    .clock (clk),
    .reset (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed magnitudes, small one truncated by min(d,25), then plain addition.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, output logic s,
                                output logic [7:0] e, output logic [24:0] m, output int lat);
    longint va, vb, tot, mag;
    int     ea, eb, sh;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    va = longint'({a[30:23] != 8'd0, a[22:0]});
    vb = longint'({b[30:23] != 8'd0, b[22:0]});
    if (ea >= eb) begin
      sh = (ea - eb > 25) ? 25 : ea - eb;
      vb = vb >>> sh;
      e  = a[30:23];
    end else begin
      sh = (eb - ea > 25) ? 25 : eb - ea;
      va = va >>> sh;
      e  = b[30:23];
    end
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    tot = va + vb;
    s   = (tot < 0);
    mag = s ? -tot : tot;
    m   = 25'(mag);
    lat = 1 + sh;
  endfunction

  // One full transaction from IDLE through handshake, checking result and latency.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [7:0] e, input logic [24:0] m,
                        input int lat);
    int cyc;
    chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({name, ".latency"}, 32'(cyc), 32'(lat));
    chk({name, ".sign"}, 32'(bus.sign), 32'(s));
    chk({name, ".exp"}, 32'(bus.exp), 32'(e));
    chk({name, ".mantissa"}, 32'(bus.mantissa), 32'(m));
    chk({name, ".shiftRight"}, 32'(bus.shiftRight), 32'(m[24]));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [31:0] ra, rb;
  logic        rs;
  logic [7:0]  re;
  logic [24:0] rm;
  int          rlat;
  int          ebi;
  int          seen;

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.mantissa", 32'(bus.mantissa), 32'd0);
    chk("rst.exp", 32'(bus.exp), 32'd0);
    chk("rst.sign", 32'(bus.sign), 32'd0);
    chk("rst.shiftRight", 32'(bus.shiftRight), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 8'h7F, 25'h1000000, 1};
    vecs[1] = '{32'h3F800000, 32'h3F000000, 1'b0, 8'h7F, 25'h0C00000, 2};
    vecs[2] = '{32'h3F800000, 32'hBF800000, 1'b0, 8'h7F, 25'h0000000, 1};
    vecs[3] = '{32'h3F000000, 32'hBF800000, 1'b1, 8'h7F, 25'h0400000, 2};
    vecs[4] = '{32'h53800000, 32'h3F800000, 1'b0, 8'hA7, 25'h0800000, 26};
    vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 8'h00, 25'h0000000, 1};
    vecs[6] = '{32'h00000001, 32'h80000003, 1'b1, 8'h00, 25'h0000002, 1};
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, vecs[i].m,
             vecs[i].lat);
    end

    // Downstream stall: outputs frozen, new operands ignored, single handshake on release.
    bus.a        = 32'h3F800000;
    bus.b        = 32'h3F800000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("stall.out_valid0", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.in_valid = (i % 2 == 0);
      tick();
      chk("stall.out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall.mantissa", 32'(bus.mantissa), 32'h1000000);
      chk("stall.exp", 32'(bus.exp), 32'h7F);
      chk("stall.sign", 32'(bus.sign), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stall.release_valid", 32'(bus.out_valid), 32'd0);
    chk("stall.release_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("stall.no_extra_result", 32'(seen), 32'd0);

    // Reset in the middle of a d=10 alignment.
    bus.a        = 32'h44800000;
    bus.b        = 32'h3F800000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("midrst.in_ready_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #2;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst.mantissa", 32'(bus.mantissa), 32'd0);
    chk("midrst.exp", 32'(bus.exp), 32'd0);
    chk("midrst.shiftRight", 32'(bus.shiftRight), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("midrst.in_ready_after", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("midrst.no_output", 32'(seen), 32'd0);

    // Random operands; even iterations keep exponents close to exercise short alignments.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ebi = int'(ra[30:23]) + int'($urandom_range(0, 30)) - 15;
        if (ebi < 0) ebi = 0;
        if (ebi > 255) ebi = 255;
        rb[30:23] = 8'(ebi);
      end
      model(ra, rb, rs, re, rm, rlat);
      run_op($sformatf("rand%0d", i), ra, rb, rs, re, rm, rlat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_align_add.md
FP_ALIGN_ADD -- requirements
Module: fp_align_add

Interface
REQ-001 The block SHALL have parameter MANTISSA_N, default 25, meaning output mantissa width (carry bit, hidden bit, 23 fraction bits).
REQ-002 The block SHALL have parameter EXP_N, default 8, meaning biased exponent width.
REQ-003 The block SHALL have port clock  input  1  as the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  as an asynchronous, active-high reset.
REQ-005 The block SHALL have port a  input  32  as IEEE-754 single-precision operand A.
REQ-006 The block SHALL have port b  input  32  as IEEE-754 single-precision operand B.
REQ-007 The block SHALL have port in_valid  input  1  meaning operands are presented.
REQ-008 The block SHALL have port in_ready  output  1  meaning the block accepts operands this cycle.
REQ-009 The block SHALL have port out_valid  output  1  meaning the result is valid for the downstream normalizer.
REQ-010 The block SHALL have port out_ready  input  1  meaning downstream consumes the result.
REQ-011 The block SHALL have port sign  output  1  as the result sign.
REQ-012 The block SHALL have port exp  output  EXP_N  as the unnormalized result exponent (larger operand exponent).
REQ-013 The block SHALL have port mantissa  output  MANTISSA_N  as the unnormalized magnitude sum (bit24 carry, bit23 hidden).
REQ-014 The block SHALL have port shiftRight  output  1  meaning mantissa bit24 is set.

Function
REQ-015 The block SHALL implement FSM states IDLE, ALIGN, ADD, DONE.
- IDLE: in_ready=1; on in_valid it captures operands.
- Capture: next state ALIGN if exponent difference d>0, else ADD.
REQ-016 On capture, the block SHALL unpack each operand as {hidden, fraction}, with hidden=1 if exponent!=0, else 0.
- The larger-exponent operand is designated "big"; on equal exponents, A is "big".
- Shift counter loads min(d,25).
REQ-017 In ALIGN, the block SHALL shift the small mantissa right by 1 bit and decrement the counter each cycle.
- Exit to ADD in the cycle the counter reaches 0.
- Shifted-out bits are discarded (no guard/sticky).
REQ-018 In ADD, the block SHALL register a single-cycle result.
- Equal signs: mantissa = big + small, sign = shared sign.
- Differing signs: mantissa = |big - small|, sign = sign of the larger magnitude.
- Exact-zero result: sign = 0.
- exp = big exponent, unmodified.
- shiftRight = mantissa[24].
- Next state DONE.
REQ-019 In DONE, out_valid SHALL be 1 and all outputs held stable until out_ready=1, then next state IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE, and in_valid SHALL be ignored in every other state.
REQ-021 Latency SHALL be 1+min(d,25) cycles from the capture edge to the out_valid rising edge.
REQ-022 Exponent 255 (Inf/NaN) inputs SHALL be processed as ordinary values; special handling is out of scope.

Reset
REQ-023 While reset is high, the block SHALL force state IDLE, out_valid=0, sign=0, exp=0, mantissa=0, shiftRight=0 and shift counter=0, independent of clock.
REQ-024 Reset asserted mid-ALIGN or mid-DONE SHALL discard the in-flight operation with no output produced.
- in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-025 The block SHALL take MANTISSA_N, EXP_N, the bias constant (127), the shift cap (25), a packed float-fields typedef {sign, exp, frac} and the FSM state enum from shared package fp_pkg.
REQ-026 Operand unpacking (field split plus hidden-bit insertion) SHALL be one sub-module, fp_unpack, instantiated twice; everything else is inline.

Verification
REQ-027 0x3F800000 + 0x3F800000 -> sign 0, exp 0x7F, mantissa 0x1000000, shiftRight 1, out_valid 1 cycle after capture.
REQ-028 0x3F800000 + 0x3F000000 -> exp 0x7F, mantissa 0x0C00000, shiftRight 0, latency 2.
REQ-029 0x3F800000 + 0xBF800000 -> mantissa 0, sign 0, exp 0x7F.
- Also 0x3F000000 + 0xBF800000 -> sign 1, mantissa 0x400000.
REQ-030 0x53800000 + 0x3F800000 (d=40) -> shift capped at 25, latency 26, mantissa 0x800000, exp 0xA7.
REQ-031 out_ready low for 5 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored.
- Release -> exactly one handshake, IDLE next cycle.
REQ-032 reset pulsed during ALIGN of a d=10 operation -> out_valid never asserts for it; outputs 0, in_ready 1 after release.
